// File: rtl/glyph_pixel_fetch_pkg.sv
// vga_font_pkg: font geometry defaults, scale codes and the built-in 8x8 debug font stretched to any glyph size
package vga_font_pkg;
  localparam int DEF_GLYPH_W = 8;
  localparam int DEF_GLYPH_H = 16;
  localparam int DEF_NUM_CHARS = 128;
  localparam logic [1:0] SCALE_1X = 2'd0;
  localparam logic [1:0] SCALE_2X = 2'd1;
  localparam logic [1:0] SCALE_4X = 2'd2;
  function automatic logic [63:0] font8x8(input int c);
    case (c)
      38: return 64'h386C3876DCCC7600;
      45: return 64'h000000FC00000000;
      58: return 64'h0030300000303000;
      48: return 64'h7CC6CEDEF6E67C00;
      49: return 64'h307030303030FC00;
      50: return 64'h78CC0C3860CCFC00;
      51: return 64'h78CC0C380CCC7800;
      52: return 64'h1C3C6CCCFE0C1E00;
      53: return 64'hFCC0F80C0CCC7800;
      54: return 64'h3860C0F8CCCC7800;
      55: return 64'hFCCC0C1830303000;
      56: return 64'h78CCCC78CCCC7800;
      57: return 64'h78CCCC7C0C187000;
      65: return 64'h3078CCCCFCCCCC00;
      66: return 64'hFC66667C6666FC00;
      67: return 64'h3C66C0C0C0663C00;
      68: return 64'hF86C6666666CF800;
      69: return 64'hFE6268786862FE00;
      70: return 64'hFE6268786860F000;
      71: return 64'h3C66C0C0CE663E00;
      72: return 64'hCCCCCCFCCCCCCC00;
      73: return 64'h7830303030307800;
      74: return 64'h1E0C0C0CCCCC7800;
      75: return 64'hE6666C786C66E600;
      76: return 64'hF06060606266FE00;
      77: return 64'hC6EEFEFED6C6C600;
      78: return 64'hC6E6F6DECEC6C600;
      79: return 64'h386CC6C6C66C3800;
      80: return 64'hFC66667C6060F000;
      81: return 64'h78CCCCCCDC781C00;
      82: return 64'hFC66667C6C66E600;
      83: return 64'h78CCE0701CCC7800;
      84: return 64'hFCB4303030307800;
      85: return 64'hCCCCCCCCCCCCFC00;
      86: return 64'hCCCCCCCCCC783000;
      87: return 64'hC6C6C6D6FEEEC600;
      88: return 64'hC6C66C38386CC600;
      89: return 64'hCCCCCC7830307800;
      90: return 64'hFEC68C183266FE00;
      91: return 64'h7860606060607800;
      93: return 64'h7818181818187800;
      120: return 64'h0000C66C386CC600;
      default: return 64'h0;
    endcase
  endfunction
  function automatic logic [15:0] font_row(input int c, input int r, input int gw, input int gh);
    logic [63:0] g = font8x8(c);
    logic [7:0] b = g[63 - 8 * ((r * 8) / gh) -: 8];
    return {b, 8'h00} >> (16 - gw);
  endfunction
endpackage

// File: rtl/glyph_pixel_fetch_if.sv
// glyph_pixel_fetch_if: pixel request (req_*), pixel response (pix_*) and glyph write (wr_*) bundle; master drives requests, slave is the engine
interface glyph_pixel_fetch_if import vga_font_pkg::*; #(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H,
  parameter int NUM_CHARS = DEF_NUM_CHARS
);
  localparam int CW = $clog2(NUM_CHARS);
  localparam int XW = $clog2(GLYPH_W) + 2;
  localparam int YW = $clog2(GLYPH_H) + 2;
  localparam int AW = CW + $clog2(GLYPH_H);
  logic req_valid;
  logic [CW-1:0] req_char;
  logic [XW-1:0] req_col;
  logic [YW-1:0] req_row;
  logic [1:0] req_scale;
  logic req_invert;
  logic pix_valid;
  logic pix_on;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [GLYPH_W-1:0] wr_data;
  modport master (output req_valid, req_char, req_col, req_row, req_scale, req_invert, wr_en, wr_addr, wr_data, input pix_valid, pix_on);
  modport slave (input req_valid, req_char, req_col, req_row, req_scale, req_invert, wr_en, wr_addr, wr_data, output pix_valid, pix_on);
endinterface

// File: rtl/glyph_pixel_fetch_mem.sv
// glyph_mem: font-preloaded dual-port RAM; clk/rst, wr_en/wr_addr/wr_data write port, rd_addr in, registered read-first rd_data out
module glyph_mem import vga_font_pkg::*; #(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H,
  parameter int NUM_CHARS = DEF_NUM_CHARS
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [$clog2(NUM_CHARS*GLYPH_H)-1:0] wr_addr,
  input  logic [GLYPH_W-1:0] wr_data,
  input  logic [$clog2(NUM_CHARS*GLYPH_H)-1:0] rd_addr,
  output logic [GLYPH_W-1:0] rd_data
);
  localparam int DEPTH = NUM_CHARS * GLYPH_H;
  function automatic logic [DEPTH*GLYPH_W-1:0] font_image();
    for (int i = 0; i < DEPTH; i++)
      font_image[i*GLYPH_W +: GLYPH_W] = GLYPH_W'(font_row(i / GLYPH_H, i % GLYPH_H, GLYPH_W, GLYPH_H));
  endfunction
  logic [DEPTH-1:0][GLYPH_W-1:0] mem = font_image();
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en && !rst) mem[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/glyph_pixel_fetch.sv
// glyph_pixel_fetch: 2-stage glyph pixel engine; clk/rst plus a slave bus of pixel requests, pixel responses and glyph writes
module glyph_pixel_fetch import vga_font_pkg::*; #(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H,
  parameter int NUM_CHARS = DEF_NUM_CHARS
) (
  input logic clk,
  input logic rst,
  glyph_pixel_fetch_if.slave bus
);
  localparam int GXW = $clog2(GLYPH_W);
  localparam int GYW = $clog2(GLYPH_H);
  localparam int XW = GXW + 2;
  localparam int YW = GYW + 2;
  logic [1:0] s;
  logic [XW-1:0] gx;
  logic [YW-1:0] gy;
  logic oob;
  logic [$clog2(NUM_CHARS)+GYW-1:0] rd_addr;
  logic [GLYPH_W-1:0] row_data;
  logic v1, inv1, oob1;
  logic [GXW-1:0] gx1;
  always_comb begin
    s = (bus.req_scale == SCALE_2X || bus.req_scale == SCALE_4X) ? bus.req_scale : SCALE_1X;
    gx = bus.req_col >> s;
    gy = bus.req_row >> s;
    oob = |gx[XW-1:GXW] || |gy[YW-1:GYW];
    rd_addr = oob ? '0 : {bus.req_char, gy[GYW-1:0]};
  end
  glyph_mem #(.GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .NUM_CHARS(NUM_CHARS)) u_mem (
    .clk, .rst, .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data), .rd_addr, .rd_data(row_data)
  );
  // ~gx1 is GLYPH_W-1-gx1 because GLYPH_W is a power of two (MSB is the leftmost pixel)
  always_ff @(posedge clk) begin
    v1 <= bus.req_valid && !rst;
    gx1 <= gx[GXW-1:0];
    inv1 <= bus.req_invert;
    oob1 <= oob;
    bus.pix_valid <= v1 && !rst;
    bus.pix_on <= v1 && !rst && !oob1 && (row_data[~gx1] ^ inv1);
  end
endmodule

// File: tb/tb_glyph_pixel_fetch.sv
// tb_glyph_pixel_fetch: randomized scoreboard bench for glyph_pixel_fetch against an arithmetic font model
module tb_glyph_pixel_fetch;
  typedef struct {bit exp; int due; bit drop;} item_t;
  bit clk;
  logic rst;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] mdl [2048];
  item_t q[$];
  glyph_pixel_fetch_if bus ();
  glyph_pixel_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic bit model(int ch, int col, int row, int sc, bit inv);
    int f = (sc == 3) ? 1 : (1 << sc);
    int gx = col / f;
    int gy = row / f;
    logic [7:0] r;
    if (gx >= 8 || gy >= 16) return 1'b0;
    r = mdl[ch * 16 + gy];
    return r[7 - gx] ^ inv;
  endfunction
  task automatic step(input bit v, input int ch, input int col, input int row, input int sc, input bit inv,
                      input bit we, input int wa, input logic [7:0] wd, input bit r, input int want);
    item_t it;
    if (r) foreach (q[i]) if (q[i].due >= cyc + 1) q[i].drop = 1'b1;
    rst = r;
    bus.req_valid = v;
    bus.req_char = 7'(ch);
    bus.req_col = 5'(col);
    bus.req_row = 6'(row);
    bus.req_scale = 2'(sc);
    bus.req_invert = inv;
    bus.wr_en = we;
    bus.wr_addr = 11'(wa);
    bus.wr_data = wd;
    if (v) begin
      it.exp = (want < 0) ? model(ch, col, row, sc, inv) : want[0];
      it.due = cyc + 2;
      it.drop = r;
      q.push_back(it);
    end
    if (we && !r) mdl[wa] = wd;
    @(negedge clk);
  endtask
  task automatic rstep(input bit v, input bit we, input bit r);
    step(v, $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 3),
         1'($urandom_range(0, 1)), we, $urandom_range(0, 2047), 8'($urandom), r, -1);
  endtask
  always @(negedge clk) begin
    item_t it;
    compared++;
    if (bus.pix_valid !== 1'b1 && bus.pix_on !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_pix_on: cyc %0d got %b want 0", cyc, bus.pix_on);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      it = q.pop_front();
      compared++;
      if (it.drop) begin
        if (bus.pix_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL dropped_valid: cyc %0d got %b want 0", cyc, bus.pix_valid);
        end
      end else if (bus.pix_valid !== 1'b1 || bus.pix_on !== it.exp) begin
        mismatched++;
        $display("FAIL pixel: cyc %0d got valid=%b on=%b want valid=1 on=%b", cyc, bus.pix_valid, bus.pix_on, it.exp);
      end
    end else if (bus.pix_valid !== 1'b0) begin
      compared++;
      mismatched++;
      $display("FAIL spurious_valid: cyc %0d got %b want 0", cyc, bus.pix_valid);
    end
  end
  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_char = '0;
    bus.req_col = '0;
    bus.req_row = '0;
    bus.req_scale = '0;
    bus.req_invert = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    @(negedge clk);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1);
    step(1, 65, 3, 3, 0, 0, 0, 0, 0, 0, 1);
    step(1, 65, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    step(1, 65, 7, 6, 1, 0, 0, 0, 0, 0, 1);
    step(1, 65, 12, 12, 2, 0, 0, 0, 0, 0, 1);
    step(1, 65, 3, 3, 3, 0, 0, 0, 0, 0, 1);
    step(1, 32, 2, 5, 0, 1, 0, 0, 0, 0, 1);
    step(1, 32, 8, 5, 0, 1, 0, 0, 0, 0, 0);
    step(1, 32, 2, 32, 1, 1, 0, 0, 0, 0, 0);
    step(1, 65, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 48, 0, 2, 0, 0, 0, 0, 0, 0, 1);
    step(1, 48, 2, 2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 65, 0, 3, 0, 0, 1, 65 * 16 + 3, 8'hFF, 0, 0);
    step(1, 65, 0, 3, 0, 0, 0, 0, 0, 0, 1);
    for (int a = 0; a < 2048; a++) step(0, 0, 0, 0, 0, 0, 1, a, 8'($urandom), 0, -1);
    for (int i = 0; i < 64; i++) rstep(1, 0, 0);
    rstep(1, 0, 0);
    rstep(1, 0, 1);
    rstep(0, 0, 1);
    rstep(1, 0, 0);
    for (int i = 0; i < 1500; i++)
      rstep($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
